// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pause, line-compare and frame interrupts
// clk, rst_n (sync, active-low), en (advance/freeze timing state)
// line_cmp/line_irq_en: raster-compare line and its enable; line_ack/frame_ack clear the sticky flags
// x/y: registered pixel/line counters; hsync/vsync/blank: registered decode of x/y, one clk behind them
// frame_count: completed frames; line_irq/frame_irq: sticky flags; irq: their OR
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP = 48,
  parameter int H_SYNC = 104,
  parameter int H_BP = 152,
  parameter int V_ACTIVE = 768,
  parameter int V_FP = 3,
  parameter int V_SYNC = 4,
  parameter int V_BP = 23,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b1,
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [YW-1:0] line_cmp,
  input  logic          line_irq_en,
  input  logic          line_ack,
  input  logic          frame_ack,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [15:0]   frame_count,
  output logic          line_irq,
  output logic          frame_irq,
  output logic          irq
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_LINE = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_ACT = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0 = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1 = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0 = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1 = YW'(V_ACTIVE + V_FP + V_SYNC);
  logic x_wrap, frame_hit, line_hit;
  assign x_wrap = x == X_LAST;
  assign frame_hit = en && x_wrap && y == Y_LAST;
  assign line_hit = en && line_irq_en && x == X_LINE && y == line_cmp;
  assign irq = line_irq | frame_irq;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      hsync <= !HSYNC_POL;
      vsync <= !VSYNC_POL;
      blank <= 1'b1;
      frame_count <= '0;
      line_irq <= 1'b0;
      frame_irq <= 1'b0;
    end else begin
      if (en) begin
        x <= x_wrap ? '0 : x + 1'b1;
        if (x_wrap) y <= (y == Y_LAST) ? '0 : y + 1'b1;
        hsync <= (x >= X_HS0 && x < X_HS1) ? HSYNC_POL : !HSYNC_POL;
        vsync <= (y >= Y_VS0 && y < Y_VS1) ? VSYNC_POL : !VSYNC_POL;
        blank <= (x >= X_ACT) || (y >= Y_ACT);
        if (frame_hit) frame_count <= frame_count + 1'b1;
      end
      // a set on the same edge as its ack wins
      line_irq <= line_hit | (line_irq & ~line_ack);
      frame_irq <= frame_hit | (frame_irq & ~frame_ack);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen using a pixel-index reference model
module tb_vga_timing_gen;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] line_cmp = '0;
  logic line_irq_en = 1'b0;
  logic line_ack = 1'b0;
  logic frame_ack = 1'b0;
  logic [3:0] x;
  logic [3:0] y;
  logic hsync, vsync, blank, line_irq, frame_irq, irq;
  logic [15:0] frame_count;
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .XW(4), .YW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .line_cmp(line_cmp), .line_irq_en(line_irq_en),
    .line_ack(line_ack), .frame_ack(frame_ack), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .blank(blank), .frame_count(frame_count), .line_irq(line_irq), .frame_irq(frame_irq), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic hs;
    logic vs;
    logic bl;
    logic [15:0] fc;
    logic li;
    logic fi;
    logic irq;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int compared = 0;
  int mismatched = 0;
  int pos = 0;
  int prev = 0;
  bit started = 0;
  int fc = 0;
  bit li = 0;
  bit fi = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // Reference: the raster is a linear pixel index advanced once per enabled edge;
  // decoded outputs describe the index that was current at the previous enabled edge.
  task automatic drive(input logic r, input logic e, input logic [3:0] lc, input logic lie,
                       input logic la, input logic fa);
    exp_t ex;
    bit lset, fset;
    int px, py;
    @(negedge clk);
    rst_n = r; en = e; line_cmp = lc; line_irq_en = lie; line_ack = la; frame_ack = fa;
    if (!r) begin
      pos = 0; started = 0; fc = 0; li = 0; fi = 0;
    end else begin
      lset = e && lie && (pos % HT == HA - 1) && (pos / HT == int'(lc));
      fset = e && (pos == FT - 1);
      li = lset || (li && !la);
      fi = fset || (fi && !fa);
      if (e) begin
        prev = pos;
        started = 1;
        pos = (pos + 1) % FT;
        if (fset) fc = (fc + 1) % 65536;
      end
    end
    px = prev % HT;
    py = prev / HT;
    ex.x = 4'(pos % HT);
    ex.y = 4'(pos / HT);
    ex.hs = !(started && px >= HA + HFP && px < HA + HFP + HS);
    ex.vs = started && py >= VA + VFP && py < VA + VFP + VS;
    ex.bl = !started || px >= HA || py >= VA;
    ex.fc = 16'(fc);
    ex.li = li;
    ex.fi = fi;
    ex.irq = li || fi;
    q.push_back(ex);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("x", 32'(x), 32'(me.x));
      chk("y", 32'(y), 32'(me.y));
      chk("hsync", 32'(hsync), 32'(me.hs));
      chk("vsync", 32'(vsync), 32'(me.vs));
      chk("blank", 32'(blank), 32'(me.bl));
      chk("frame_count", 32'(frame_count), 32'(me.fc));
      chk("line_irq", 32'(line_irq), 32'(me.li));
      chk("frame_irq", 32'(frame_irq), 32'(me.fi));
      chk("irq", 32'(irq), 32'(me.irq));
    end
  end
  initial begin
    logic [3:0] lc;
    repeat (3) drive(0, 0, 4'd0, 0, 0, 0);
    repeat (130) drive(1, 1, 4'd0, 0, 0, 0);
    for (int i = 0; i < 40 && pos % HT != 5; i++) drive(1, 1, 4'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 0, 4'd0, 0, 0, i == 7);
    repeat (4) drive(1, 1, 4'd0, 0, 0, 0);
    for (int i = 0; i < 200 && pos != 2 * HT + HA - 1; i++) drive(1, 1, 4'd2, 1, 0, 0);
    drive(1, 1, 4'd2, 1, 1, 0);
    drive(1, 1, 4'd2, 1, 1, 0);
    repeat (20) drive(1, 1, 4'd2, 1, 0, 0);
    lc = 4'd0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) lc = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 7) != 0, lc,
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    for (int i = 0; i < 300 && pos != 6 * HT + 11; i++) drive(1, 1, 4'd3, 1, 0, 0);
    drive(0, 1, 4'd3, 1, 0, 0);
    repeat (140) drive(1, 1, 4'd3, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
